wordline_scan_encoder: RTL

Sequential 16-to-4 encoder, the inverse of the register-file write decoder. It accepts a 16-bit one-hot-per-register mask (a wordline set, e.g. a dirty/valid vector) and emits the 4-bit register ID of every set bit, lowest index first, one per accepted handshake. It sits between register-file status logic and any consumer that walks registers serially, such as a register dump, context save or debug scan.

---
 rtl/wordline_scan_encoder_if.sv | 23 ++
 rtl/wordline_scan_encoder.sv | 90 +++++++++
 2 files changed

// File: rtl/wordline_scan_encoder_if.sv
// Handshake bundle between wordline_scan_encoder and its controller/consumer.
// The encoder uses the slave side; the requester/consumer uses the master side.
interface wordline_scan_encoder_if;
    logic        Start;
    logic [15:0] Mask;
    logic        Abort;
    logic [3:0]  RegId;
    logic        IdValid;
    logic        IdReady;
    logic        Busy;
    logic        Done;
    logic [4:0]  Count;

    modport master (
        output Start, Mask, Abort, IdReady,
        input  RegId, IdValid, Busy, Done, Count
    );

    modport slave (
        input  Start, Mask, Abort, IdReady,
        output RegId, IdValid, Busy, Done, Count
    );
endinterface

// File: rtl/wordline_scan_encoder.sv
// Sequential 16-to-4 encoder: walks a wordline mask and emits the register ID
// of each set bit, lowest index first, one per IdValid/IdReady handshake.
module wordline_scan_encoder (
    input  logic                    clk,
    input  logic                    rst,
    wordline_scan_encoder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pending_q, pending_d;
    logic [4:0]  count_q, count_d;
    logic [3:0]  low_idx;
    logic [15:0] pending_cleared;

    // Descending loop so the last hit, i.e. the lowest set bit, wins.
    always_comb begin
        low_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pending_q[i]) low_idx = 4'(i);
        end
    end

    // x & (x-1) drops exactly the lowest set bit, the one currently presented.
    assign pending_cleared = pending_q & (pending_q - 16'd1);

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        count_d     = count_q;
        bus.RegId   = 4'd0;
        bus.IdValid = 1'b0;
        bus.Busy    = 1'b0;
        bus.Done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    pending_d = bus.Mask;
                    count_d   = 5'd0;
                    state_d   = (bus.Mask != 16'd0) ? SCAN : DONE;
                end
            end
            SCAN: begin
                bus.IdValid = 1'b1;
                bus.Busy    = 1'b1;
                bus.RegId   = low_idx;
                // Abort wins over a coincident handshake: that ID is not counted.
                if (bus.Abort) begin
                    pending_d = 16'd0;
                    state_d   = IDLE;
                end else if (bus.IdReady) begin
                    pending_d = pending_cleared;
                    count_d   = count_q + 5'd1;
                    if (pending_cleared == 16'd0) state_d = DONE;
                end
            end
            DONE: begin
                bus.Busy = 1'b1;
                bus.Done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 16'd0;
            count_q   <= 5'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign bus.Count = count_q;

endmodule
